// File: rtl/frame_loader_pkg.sv
// Shared video definitions: frame geometry defaults, loader state encoding and
// RGB444 field layout used by both the frame loader and the display path.
package frame_loader_pkg;

  localparam int VID_H_LEN      = 200;
  localparam int VID_V_LEN      = 150;
  localparam int VID_DW         = 15;
  localparam int VID_NUM_FRAMES = 10;

  localparam int PIX_W     = 12;
  localparam int RGB_R_MSB = 11;
  localparam int RGB_R_LSB = 8;
  localparam int RGB_G_MSB = 7;
  localparam int RGB_G_LSB = 4;
  localparam int RGB_B_MSB = 3;
  localparam int RGB_B_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2
  } load_state_t;

  function automatic logic [PIX_W-1:0] pack_rgb444(input logic [3:0] r,
                                                   input logic [3:0] g,
                                                   input logic [3:0] b);
    logic [PIX_W-1:0] p;
    p = '0;
    p[RGB_R_MSB:RGB_R_LSB] = r;
    p[RGB_G_MSB:RGB_G_LSB] = g;
    p[RGB_B_MSB:RGB_B_LSB] = b;
    return p;
  endfunction

endpackage

// File: rtl/frame_loader_pixel_packer.sv
// Assembles one RGB444 pixel from a byte pair: byte 0 carries {R,G} and is held
// here, byte 1 supplies B in its low nibble and is combined on the fly.
module pixel_packer
  import frame_loader_pkg::*;
(
  input  logic             pclk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_load_rg,
  input  logic [7:0]       i_byte,
  output logic [PIX_W-1:0] o_pixel
);

  logic [7:0] r_rg;

  always_ff @(posedge pclk) begin
    if (rst || i_clear) begin
      r_rg <= '0;
    end else if (i_load_rg) begin
      r_rg <= i_byte;
    end
  end

  // The high nibble of byte 1 carries no colour information and is dropped.
  assign o_pixel = pack_rgb444(r_rg[7:4], r_rg[3:0], i_byte[3:0]);

endmodule

// File: rtl/frame_loader.sv
// Loads a run of RGB444 frames from a byte stream into consecutive VRAM frame
// slots, one registered write per received byte pair.
module frame_loader
  import frame_loader_pkg::*;
#(
  parameter int H_LEN      = VID_H_LEN,
  parameter int V_LEN      = VID_V_LEN,
  parameter int DW         = VID_DW,
  parameter int NUM_FRAMES = VID_NUM_FRAMES
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          start,
  input  logic [3:0]    first_frame,
  input  logic [3:0]    num_load,
  input  logic          abort,
  input  logic [7:0]    s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic          we,
  output logic [DW-1:0] waddr,
  output logic [11:0]   wdata,
  output logic [3:0]    wframe,
  output logic          busy,
  output logic          frame_done,
  output logic          load_done,
  output logic          err,
  output logic [1:0]    o_dbg_state
);

  localparam logic [DW-1:0] LAST_ADDR = DW'(H_LEN * V_LEN - 1);
  localparam logic [3:0]    NF_MAX    = 4'(NUM_FRAMES);
  localparam logic [3:0]    NF_LAST   = 4'(NUM_FRAMES - 1);

  // Handshake: a byte moves on a pclk edge where s_valid and s_ready are both
  // high; s_ready is registered, so the source may hold s_valid indefinitely.
  load_state_t   r_state;
  logic          r_s_ready;
  logic          r_we;
  logic [DW-1:0] r_waddr;
  logic [11:0]   r_wdata;
  logic [3:0]    r_wframe;
  logic          r_busy;
  logic          r_frame_done;
  logic          r_load_done;
  logic          r_err;
  logic [3:0]    r_remaining;

  logic          w_abort;
  logic          w_hs;
  logic          w_load_rg;
  logic          w_last_addr;
  logic          w_final_px;
  logic          w_start_ok;
  logic [3:0]    w_next_frame;
  logic [11:0]   w_pixel;

  assign w_abort      = abort && (r_state != ST_IDLE);
  assign w_hs         = s_valid && r_s_ready;
  assign w_load_rg    = w_hs && (r_state == ST_HI) && !abort;
  assign w_last_addr  = (r_waddr == LAST_ADDR);
  assign w_final_px   = w_last_addr && (r_remaining == 4'd1);
  assign w_start_ok   = (num_load != 4'd0) && (num_load <= NF_MAX) &&
                        (first_frame <= NF_LAST);
  assign w_next_frame = (r_wframe == NF_LAST) ? 4'd0 : r_wframe + 4'd1;

  pixel_packer u_packer (
    .pclk      (pclk),
    .rst       (rst),
    .i_clear   (w_abort),
    .i_load_rg (w_load_rg),
    .i_byte    (s_data),
    .o_pixel   (w_pixel)
  );

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_s_ready    <= 1'b0;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_wframe     <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_load_done  <= 1'b0;
      r_err        <= 1'b0;
      r_remaining  <= '0;
    end else begin
      r_we         <= 1'b0;
      r_frame_done <= 1'b0;
      r_load_done  <= 1'b0;

      // Address/slot bookkeeping happens as the write retires, so waddr and
      // wframe describe the write for the whole cycle that we is high.
      if (r_we) begin
        if (r_frame_done) begin
          r_waddr     <= '0;
          r_wframe    <= w_next_frame;
          r_remaining <= r_remaining - 4'd1;
        end else begin
          r_waddr <= r_waddr + 1'b1;
        end
      end

      if (w_abort) begin
        r_state   <= ST_IDLE;
        r_s_ready <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (start) begin
              if (w_start_ok) begin
                r_err       <= 1'b0;
                r_wframe    <= first_frame;
                r_waddr     <= '0;
                r_remaining <= num_load;
                r_state     <= ST_HI;
                r_s_ready   <= 1'b1;
                r_busy      <= 1'b1;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
          ST_HI: begin
            // The final write of a load is spent in HI with s_ready low.
            if (r_we && r_load_done) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else if (w_hs) begin
              r_state <= ST_LO;
            end
          end
          ST_LO: begin
            if (w_hs) begin
              r_state      <= ST_HI;
              r_we         <= 1'b1;
              r_wdata      <= w_pixel;
              r_frame_done <= w_last_addr;
              r_load_done  <= w_final_px;
              if (w_final_px) begin
                r_s_ready <= 1'b0;
              end
            end
          end
          default: begin
            r_state   <= ST_IDLE;
            r_s_ready <= 1'b0;
            r_busy    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign s_ready     = r_s_ready;
  assign we          = r_we;
  assign waddr       = r_waddr;
  assign wdata       = r_wdata;
  assign wframe      = r_wframe;
  assign busy        = r_busy;
  assign frame_done  = r_frame_done;
  assign load_done   = r_load_done;
  assign err         = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_frame_loader.sv
// Bench for frame_loader: a 2x1 instance for the single-pixel case and a 16x8
// instance (10 slots) for wrap, rejection, gap, abort and reset scenarios.
module tb_frame_loader;

  localparam int H         = 16;
  localparam int V         = 8;
  localparam int NF        = 10;
  localparam int FRAME_PIX = H * V;

  logic       pclk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       s_valid = 1'b0;
  logic [3:0] first_frame = 4'd0;
  logic [3:0] num_load = 4'd0;
  logic [7:0] s_data = 8'd0;

  logic        d_s_ready, d_we, d_busy, d_frame_done, d_load_done, d_err;
  logic [14:0] d_waddr;
  logic [11:0] d_wdata;
  logic [3:0]  d_wframe;
  logic [1:0]  d_dbg;
  logic        t_s_ready, t_we, t_busy, t_frame_done, t_load_done, t_err;
  logic [14:0] t_waddr;
  logic [11:0] t_wdata;
  logic [3:0]  t_wframe;
  logic [1:0]  t_dbg;

  frame_loader #(.H_LEN(H), .V_LEN(V), .DW(15), .NUM_FRAMES(NF)) u_dut (
    .pclk(pclk), .rst(rst), .start(start), .first_frame(first_frame),
    .num_load(num_load), .abort(abort), .s_data(s_data), .s_valid(s_valid),
    .s_ready(d_s_ready), .we(d_we), .waddr(d_waddr), .wdata(d_wdata),
    .wframe(d_wframe), .busy(d_busy), .frame_done(d_frame_done),
    .load_done(d_load_done), .err(d_err), .o_dbg_state(d_dbg)
  );

  frame_loader #(.H_LEN(2), .V_LEN(1), .DW(15), .NUM_FRAMES(NF)) u_small (
    .pclk(pclk), .rst(rst), .start(start), .first_frame(first_frame),
    .num_load(num_load), .abort(abort), .s_data(s_data), .s_valid(s_valid),
    .s_ready(t_s_ready), .we(t_we), .waddr(t_waddr), .wdata(t_wdata),
    .wframe(t_wframe), .busy(t_busy), .frame_done(t_frame_done),
    .load_done(t_load_done), .err(t_err), .o_dbg_state(t_dbg)
  );

  // Clock / reset
  always #5 pclk = ~pclk;

  logic [36:0] d_outs, t_outs;
  assign d_outs = {d_we, d_waddr, d_wdata, d_wframe, d_s_ready, d_busy,
                   d_frame_done, d_load_done, d_err};
  assign t_outs = {t_we, t_waddr, t_wdata, t_wframe, t_s_ready, t_busy,
                   t_frame_done, t_load_done, t_err};

  // Scoreboard and pixel-level model: one entry {ld, fd, frame, addr, pixel}
  int          n_vec = 0;
  int          n_err = 0;
  bit          chk_en = 1'b0;
  bit          m_busy = 1'b0;
  bit          m_err = 1'b0;
  bit          m_phase = 1'b0;
  logic [7:0]  m_rg = 8'd0;
  int          m_frame = 0;
  int          m_addr = 0;
  int          m_rem = 0;
  logic [32:0] exp_q[$];
  logic [32:0] wr_log[$];
  logic [32:0] log_a[$];
  bit          log_en = 1'b0;
  int          cnt_we = 0, cnt_fd = 0, cnt_ld = 0, cnt_f9 = 0, cnt_f0 = 0;
  int          last_addr = 0, ld_addr = 0, ld_frame = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    cnt_we = 0; cnt_fd = 0; cnt_ld = 0; cnt_f9 = 0; cnt_f0 = 0;
    last_addr = 0; ld_addr = 0; ld_frame = 0;
  endtask

  function automatic logic [7:0] b0_of(input int k);
    return 8'(k * 37 + 5);
  endfunction

  function automatic logic [7:0] b1_of(input int k);
    return 8'(k * 11 + 3);
  endfunction

  task automatic model_byte(input logic [7:0] b);
    logic fd, ld;
    if (!m_phase) begin
      m_rg    = b;
      m_phase = 1'b1;
    end else begin
      m_phase = 1'b0;
      fd = (m_addr == FRAME_PIX - 1);
      ld = fd && (m_rem == 1);
      exp_q.push_back({ld, fd, 4'(m_frame), 15'(m_addr), m_rg, b[3:0]});
      if (fd) begin
        m_addr  = 0;
        m_frame = (m_frame + 1) % NF;
        m_rem   = m_rem - 1;
      end else begin
        m_addr = m_addr + 1;
      end
    end
  endtask

  always @(negedge pclk) begin
    logic [32:0] e;
    if (chk_en) begin
      chk("err", d_err, m_err);
      chk("busy", d_busy, m_busy);
      if (d_we) begin
        cnt_we++;
        last_addr = d_waddr;
        if (d_frame_done) cnt_fd++;
        if (d_load_done) begin
          cnt_ld++;
          ld_addr  = d_waddr;
          ld_frame = d_wframe;
        end
        if (d_wframe == 4'd9) cnt_f9++;
        if (d_wframe == 4'd0) cnt_f0++;
        if (log_en) wr_log.push_back({d_load_done, d_frame_done, d_wframe, d_waddr, d_wdata});
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_we: waddr=%0d wframe=%0d wdata=0x%0h, no write expected",
                   d_waddr, d_wframe, d_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("write", {d_load_done, d_frame_done, d_wframe, d_waddr, d_wdata}, e);
          if (e[32]) m_busy = 1'b0;
        end
      end else if (d_frame_done || d_load_done) begin
        n_vec++;
        n_err++;
        $display("FAIL stray_done: frame_done=%b load_done=%b without we, required 0",
                 d_frame_done, d_load_done);
      end
    end
  end

  // Driver tasks: all called just after a rising edge
  task automatic do_reset(input int cycles);
    rst = 1'b1; s_valid = 1'b0; start = 1'b0; abort = 1'b0;
    @(posedge pclk); #1;
    m_busy = 1'b0; m_err = 1'b0; m_phase = 1'b0;
    repeat (cycles - 1) begin @(posedge pclk); #1; end
    rst = 1'b0;
    chk("queue_after_reset", exp_q.size(), 0);
  endtask

  task automatic do_start(input int ff, input int n);
    start = 1'b1; first_frame = 4'(ff); num_load = 4'(n);
    @(posedge pclk); #1;
    start = 1'b0;
    if (!m_busy) begin
      if (n >= 1 && n <= NF && ff < NF) begin
        m_busy = 1'b1; m_err = 1'b0; m_frame = ff; m_addr = 0; m_rem = n; m_phase = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(posedge pclk); #1;
    abort = 1'b0;
    m_busy = 1'b0; m_phase = 1'b0;
    chk("busy_after_abort", d_busy, 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t = 0;
    if (gaps && $urandom_range(0, 1) == 1)
      repeat ($urandom_range(1, 2)) begin @(posedge pclk); #1; end
    while (d_s_ready !== 1'b1 && t < 50) begin @(posedge pclk); #1; t++; end
    if (d_s_ready !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL s_ready_timeout: s_ready=%b, required 1", d_s_ready);
      return;
    end
    s_valid = 1'b1; s_data = b;
    @(posedge pclk); #1;
    s_valid = 1'b0;
    model_byte(b);
  endtask

  task automatic send_pixels(input int first, input int count, input bit gaps);
    for (int k = first; k < first + count; k++) begin
      send_byte(b0_of(k), gaps);
      send_byte(b1_of(k), gaps);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (d_busy && t < 20) begin @(posedge pclk); #1; t++; end
    chk("wait_idle", d_busy, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge pclk); #1; end
  endtask

  initial begin
    do_reset(2);
    chk_en = 1'b1;
    chk("reset_outputs_main", d_outs, 0);
    chk("reset_outputs_small", t_outs, 0);

    // Single pixel frame on the 2x1 instance
    do_start(3, 1);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h0C, 1'b0);
    @(negedge pclk);
    chk("small_px0", {t_we, t_frame_done, t_load_done, t_wframe, t_waddr, t_wdata},
        {1'b1, 1'b0, 1'b0, 4'd3, 15'd0, 12'hA5C});
    chk("main_px0", {d_we, d_wframe, d_waddr, d_wdata}, {1'b1, 4'd3, 15'd0, 12'hA5C});
    @(posedge pclk); #1;
    send_byte(8'h12, 1'b0);
    send_byte(8'h03, 1'b0);
    @(negedge pclk);
    chk("small_px1", {t_we, t_frame_done, t_load_done, t_wframe, t_waddr, t_wdata},
        {1'b1, 1'b1, 1'b1, 4'd3, 15'd1, 12'h123});
    chk("small_ready_last", t_s_ready, 0);
    @(posedge pclk); #1;
    chk("small_busy_after", t_busy, 0);
    do_reset(2);

    // Rejected requests, then a valid one clears err
    clear_stats();
    do_start(2, 0);
    chk("err_num0", {d_err, d_busy}, 2'b10);
    do_start(10, 1);
    chk("err_ff10", {d_err, d_busy}, 2'b10);
    do_start(0, 11);
    chk("err_num11", {d_err, d_busy}, 2'b10);
    idle(2);
    chk("no_we_rejected", cnt_we, 0);
    do_start(4, 1);
    chk("err_cleared", {d_err, d_busy}, 2'b01);
    do_abort();

    // Two frames from slot 9 wrapping to slot 0, with an ignored start mid-load
    clear_stats();
    do_start(9, 2);
    send_pixels(0, 60, 1'b0);
    do_start(4, 0);
    chk("start_ignored", {d_err, d_busy}, 2'b01);
    send_pixels(60, 2 * FRAME_PIX - 60, 1'b0);
    wait_idle();
    chk("wrap_f9_writes", cnt_f9, FRAME_PIX);
    chk("wrap_f0_writes", cnt_f0, FRAME_PIX);
    chk("wrap_frame_done", cnt_fd, 2);
    chk("wrap_load_done", cnt_ld, 1);
    chk("wrap_ld_addr", ld_addr, FRAME_PIX - 1);
    chk("wrap_ld_frame", ld_frame, 0);
    chk("ready_after_load", d_s_ready, 0);

    // Same frame with and without s_valid gaps
    wr_log.delete();
    log_en = 1'b1;
    do_start(0, 1);
    send_pixels(0, FRAME_PIX, 1'b0);
    wait_idle();
    log_a = wr_log;
    wr_log.delete();
    do_start(0, 1);
    send_pixels(0, FRAME_PIX, 1'b1);
    wait_idle();
    log_en = 1'b0;
    chk("nogap_len", log_a.size(), FRAME_PIX);
    chk("gap_len", wr_log.size(), FRAME_PIX);
    for (int i = 0; i < FRAME_PIX && i < log_a.size() && i < wr_log.size(); i++)
      chk("gap_seq", wr_log[i], log_a[i]);

    // Abort with pixel 100 half received
    clear_stats();
    do_start(0, 1);
    send_pixels(0, 100, 1'b0);
    send_byte(b0_of(100), 1'b0);
    do_abort();
    idle(3);
    chk("abort_writes", cnt_we, 100);
    chk("abort_last_addr", last_addr, 99);
    chk("abort_no_done", cnt_fd + cnt_ld, 0);
    do_start(0, 1);
    send_byte(8'h3C, 1'b0);
    send_byte(8'hF7, 1'b0);
    @(negedge pclk);
    chk("restart_px0", {d_we, d_wframe, d_waddr, d_wdata}, {1'b1, 4'd0, 15'd0, 12'h3C7});
    @(posedge pclk); #1;
    do_reset(2);

    // Reset mid-frame between bytes
    clear_stats();
    do_start(2, 1);
    send_pixels(0, 10, 1'b0);
    send_byte(b0_of(10), 1'b0);
    do_reset(2);
    idle(3);
    chk("rst_mid_outputs", d_outs, 0);
    chk("rst_mid_writes", cnt_we, 10);

    // Reset on the same edge as a byte-1 handshake
    clear_stats();
    do_start(1, 1);
    send_pixels(0, 5, 1'b0);
    send_byte(b0_of(5), 1'b0);
    s_valid = 1'b1; s_data = b1_of(5); rst = 1'b1;
    @(posedge pclk); #1;
    s_valid = 1'b0;
    m_busy = 1'b0; m_err = 1'b0; m_phase = 1'b0;
    @(posedge pclk); #1;
    rst = 1'b0;
    idle(3);
    chk("rst_hs_outputs", d_outs, 0);
    chk("rst_hs_writes", cnt_we, 5);

    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, bench did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/frame_loader.md
FRAME_LOADER -- requirements
Module: frame_loader

Interface
REQ-001 SHALL have parameter H_LEN, default 200: frame width in pixels.
REQ-002 SHALL have parameter V_LEN, default 150: frame height in lines.
REQ-003 SHALL have parameter DW, default 15: VRAM address width.
REQ-004 SHALL have parameter NUM_FRAMES, default 10: number of frame slots in VRAM.
REQ-005 SHALL have ports: pclk  in  1  pixel clock, the only clock; rst  in  1  synchronous active-high reset.
REQ-006 SHALL have ports: start  in  1  load request; first_frame  in  4  first slot to write; num_load  in  4  frames to load; abort  in  1  cancel load.
REQ-007 SHALL have ports: s_data  in  8  byte stream; s_valid  in  1  byte valid; s_ready  out  1  byte accepted when s_valid&s_ready.
REQ-008 SHALL have ports: we  out  1  VRAM write strobe; waddr  out  DW  write address; wdata  out  12  RGB444 pixel; wframe  out  4  target frame slot.
REQ-009 SHALL have ports: busy  out  1  load in progress; frame_done  out  1  one-cycle pulse; load_done  out  1  one-cycle pulse; err  out  1  sticky request error.

Function
REQ-010 SHALL implement states IDLE, HI (await byte 0), LO (await byte 1).
REQ-011 SHALL assert s_ready only in HI or LO, and busy whenever the state is not IDLE.
REQ-012 SHALL, in IDLE with start=1, accept only if num_load in 1..NUM_FRAMES and first_frame < NUM_FRAMES; otherwise set err and stay in IDLE.
REQ-013 SHALL, on accepted start: clear err, load wframe=first_frame, waddr=0, remaining=num_load, then go to HI.
REQ-014 SHALL ignore start while busy; this is not an error.
REQ-015 SHALL pack pixels: byte 0 = {R[3:0],G[3:0]}, byte 1 low nibble = B[3:0], high nibble ignored; wdata = {R,G,B}.
REQ-016 SHALL, on byte-0 handshake, latch R,G and go to LO; on byte-1 handshake, go to HI.
REQ-017 SHALL assert we for exactly one cycle, in the cycle after the byte-1 handshake, with waddr/wdata/wframe stable in that cycle (latency 1).
REQ-018 SHALL increment waddr after each write; writing address H_LEN*V_LEN-1 ends the frame.
REQ-019 SHALL, on the last write of a frame, pulse frame_done in the same cycle as that we, reset waddr to 0, and advance wframe with wrap from NUM_FRAMES-1 to 0.
REQ-020 SHALL decrement remaining at each frame end; when it reaches 0, pulse load_done together with frame_done and return to IDLE without accepting further bytes.
REQ-021 SHALL keep the HI/LO position and all outputs unchanged while s_valid=0 (stalls allowed anywhere).
REQ-022 SHALL, on abort while busy, go to IDLE next cycle, suppress any pending we, discard a half-received pixel, and issue no done pulses; err is unchanged.
REQ-023 SHALL give abort priority over start in the same cycle; abort in IDLE has no effect.

Reset
REQ-024 SHALL, on rst=1 at a pclk edge, force state IDLE, we=0, waddr=0, wdata=0, wframe=0, s_ready=0, busy=0, frame_done=0, load_done=0, err=0, remaining=0.
REQ-025 SHALL, on rst mid-load, discard all partial data with no further writes.

Structure
REQ-026 SHALL take H_LEN, V_LEN, DW, NUM_FRAMES, the state encoding, and the RGB444 field positions from the shared video package also used by the display path.
REQ-027 SHALL contain one sub-module, pixel_packer, for the byte-pair-to-RGB444 assembly; the FSM, counters and flags SHALL stay in frame_loader.

Verification
REQ-028 SHALL verify single pixel: H_LEN=2, V_LEN=1, start(first_frame=3, num_load=1), bytes 0xA5,0x0C,0x12,0x03 -> we at waddr 0 with wdata 0xA5C, then at waddr 1 with wdata 0x123; frame_done and load_done on the second we; busy=0 next cycle.
REQ-029 SHALL verify wrap with defaults: start(first_frame=9, num_load=2) with a full byte stream -> 30000 writes to wframe 9, then 30000 to wframe 0; frame_done twice; load_done once, on the final write (waddr 29999).
REQ-030 SHALL verify rejected start: start with num_load=0, then with first_frame=10 -> err=1, busy=0, no we; a later valid start clears err.
REQ-031 SHALL verify random s_valid gaps (about 50%) over one frame -> write sequence identical to the gap-free run.
REQ-032 SHALL verify abort after byte 0 at pixel 100 -> no we for pixel 100, busy=0 next cycle, no done pulses; a new start writes from waddr 0.
REQ-033 SHALL verify rst asserted mid-frame and in the same cycle as the byte-1 handshake -> no we afterwards, all outputs at reset values.
